mcdf_arbiter: RTL and testbench
===============================

MCDF_ARBITER -- requirements
Module: mcdf_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4: maximum cycles from ack to first valid beat.
REQ-002 clk_i  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 slvN_req_i  input  1  channel N (N=0,1,2) has a full packet ready.
REQ-005 slvN_val_i  input  1  channel N data beat valid.
REQ-006 slvN_data_i  input  32  channel N data beat.
REQ-007 slvN_pkglen_i  input  3  channel N packet-length code.
REQ-008 fmt_busy_i  input  1  downstream formatter cannot accept a new packet.
REQ-009 a2sN_ack_o  output  1  grant to channel N, single-cycle pulse.
REQ-010 arb_val_o  output  1  forwarded beat valid.
REQ-011 arb_data_o  output  32  forwarded beat data.
REQ-012 arb_id_o  output  2  source channel of the current packet (0..2).
REQ-013 arb_sop_o  output  1  first beat of the packet.
REQ-014 arb_eop_o  output  1  last beat of the packet.
REQ-015 err_o  output  1  single-cycle pulse on a timeout abort.

Function
REQ-016 FSM states: IDLE, ACK, WAIT_VAL, XFER; all outputs registered.
REQ-017 IDLE: if any req_i is high and fmt_busy_i=0, select a channel by round-robin, latch its id and length, and go to ACK; otherwise stay in IDLE.
REQ-018 Round-robin: pointer resets to ch0; search order is pointer, pointer+1, pointer+2 (mod 3); after a grant to ch k, pointer = (k+1) mod 3, including when that grant later aborts.
REQ-019 ACK: a2sk_ack_o is high for exactly this one cycle; go to WAIT_VAL; other ack outputs stay 0.
REQ-020 Length: beats = 4 << code for codes 0..4 (4,8,16,32,64); codes 5..7 are treated as 64; the code is latched in IDLE when the grant is made.
REQ-021 WAIT_VAL: the first cycle with selected val_i=1 is beat 0; on that beat go to XFER (or IDLE if beats=1, not reachable); after TIMEOUT cycles without val, pulse err_o and return to IDLE.
REQ-022 Forwarding latency is 1 cycle: arb_val_o and arb_data_o in cycle n+1 equal the selected channel's val_i and data_i in cycle n; arb_id_o holds the latched id for the whole packet.
REQ-023 XFER: a 7-bit beat counter increments on each selected val_i; gaps (val_i=0) hold the count and are not errors.
REQ-024 arb_sop_o=1 with the beat-0 arb_val_o only; arb_eop_o=1 with the beat (beats-1) arb_val_o only; after the eop beat, go to IDLE.
REQ-025 Non-selected channels' val_i and data_i are ignored; req_i is ignored outside IDLE.
REQ-026 Selected val_i beyond the packet length is ignored (not forwarded).
REQ-027 Earliest next grant: the IDLE cycle following eop capture; back-to-back packets are allowed.
REQ-028 fmt_busy_i is sampled only in IDLE; it has no effect on a packet in flight.
REQ-029 arb_data_o holds its last value when arb_val_o=0.

Reset
REQ-030 While rst_n=0: state=IDLE, pointer=ch0, counter=0, and all outputs 0, taking effect immediately (asynchronously).
REQ-031 Reset mid-packet abandons the transfer; no eop or err_o is produced; after release, operation restarts from IDLE with pointer=ch0.

Verification
REQ-032 Reset released, no req -> all outputs 0 for 20 cycles.
REQ-033 Only slv1_req_i=1, pkglen=0, data 0xA0..0xA3 on val beats starting 1 cycle after ack -> one a2s1_ack_o pulse; 4 arb_val_o beats with id=1, data 0xA0..0xA3 each 1 cycle later; sop on 0xA0, eop on 0xA3.
REQ-034 All three req held high, pkglen=1 -> grant order ch0, ch1, ch2, ch0, each packet 8 beats.
REQ-035 slv2_req_i=1 with fmt_busy_i=1 for 10 cycles -> no ack; ack issued the cycle after busy deasserts (IDLE sample).
REQ-036 Ack to ch0 with val never asserted -> err_o pulse exactly TIMEOUT cycles after ack; return to IDLE; next grant goes to ch1 if it is requesting.
REQ-037 rst_n pulled low at beat 2 of a 16-beat ch2 packet -> outputs 0 immediately; after release with ch0 and ch2 requesting, ch0 is granted first.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// Three-channel round-robin packet arbiter in front of the MCDF formatter.
// Grants one packet at a time and forwards its beats with one cycle of latency.
module mcdf_arbiter #(
    parameter int TIMEOUT = 4   // cycles from ack to the err_o pulse; must be >= 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        slv0_req_i,
    input  logic        slv0_val_i,
    input  logic [31:0] slv0_data_i,
    input  logic [2:0]  slv0_pkglen_i,
    input  logic        slv1_req_i,
    input  logic        slv1_val_i,
    input  logic [31:0] slv1_data_i,
    input  logic [2:0]  slv1_pkglen_i,
    input  logic        slv2_req_i,
    input  logic        slv2_val_i,
    input  logic [31:0] slv2_data_i,
    input  logic [2:0]  slv2_pkglen_i,
    input  logic        fmt_busy_i,
    output logic        a2s0_ack_o,
    output logic        a2s1_ack_o,
    output logic        a2s2_ack_o,
    output logic        arb_val_o,
    output logic [31:0] arb_data_o,
    output logic [1:0]  arb_id_o,
    output logic        arb_sop_o,
    output logic        arb_eop_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_VAL, XFER} state_t;

    localparam logic [7:0] WLIM = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [1:0]  ptr, ptr_nx;
    logic [1:0]  id_nx;
    logic [6:0]  last, last_nx;     // beats - 1 of the granted packet
    logic [6:0]  cnt, cnt_nx;
    logic [7:0]  wcnt, wcnt_nx;
    logic [2:0]  ack, ack_nx;
    logic        val_nx, sop_nx, eop_nx, err_nx;
    logic [31:0] data_nx;

    // Channel views padded to four entries so a 2-bit index is always in range.
    logic [3:0]  req, val;
    logic [31:0] data [0:3];
    logic [2:0]  len  [0:3];

    assign req = {1'b0, slv2_req_i, slv1_req_i, slv0_req_i};
    assign val = {1'b0, slv2_val_i, slv1_val_i, slv0_val_i};
    assign data[0] = slv0_data_i;
    assign data[1] = slv1_data_i;
    assign data[2] = slv2_data_i;
    assign data[3] = '0;
    assign len[0]  = slv0_pkglen_i;
    assign len[1]  = slv1_pkglen_i;
    assign len[2]  = slv2_pkglen_i;
    assign len[3]  = '0;

    assign a2s0_ack_o = ack[0];
    assign a2s1_ack_o = ack[1];
    assign a2s2_ack_o = ack[2];

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [6:0] len_last(input logic [2:0] code);
        case (code)
            3'd0:    return 7'd3;
            3'd1:    return 7'd7;
            3'd2:    return 7'd15;
            3'd3:    return 7'd31;
            default: return 7'd63;
        endcase
    endfunction

    logic       hit;
    logic [1:0] gid;
    logic       sel_val;
    logic [31:0] sel_data;

    // Walk offsets high to low so the lowest offset from the pointer wins.
    always_comb begin
        hit = 1'b0;
        gid = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req[rr_idx(ptr, 2'(i))]) begin
                hit = 1'b1;
                gid = rr_idx(ptr, 2'(i));
            end
        end
    end

    assign sel_val  = val[arb_id_o];
    assign sel_data = data[arb_id_o];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        id_nx    = arb_id_o;
        last_nx  = last;
        cnt_nx   = cnt;
        wcnt_nx  = wcnt;
        ack_nx   = 3'b000;
        val_nx   = 1'b0;
        data_nx  = arb_data_o;
        sop_nx   = 1'b0;
        eop_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (hit && !fmt_busy_i) begin
                    id_nx    = gid;
                    last_nx  = len_last(len[gid]);
                    ptr_nx   = (gid == 2'd2) ? 2'd0 : gid + 2'd1;
                    ack_nx   = 3'b001 << gid;
                    state_nx = ACK;
                end
            end
            ACK: begin
                cnt_nx   = '0;
                wcnt_nx  = 8'd1;
                state_nx = WAIT_VAL;
            end
            WAIT_VAL: begin
                if (sel_val) begin
                    val_nx  = 1'b1;
                    data_nx = sel_data;
                    sop_nx  = 1'b1;
                    if (last == '0) begin
                        eop_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx   = 7'd1;
                        state_nx = XFER;
                    end
                end else if (wcnt >= WLIM) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = wcnt + 8'd1;
                end
            end
            XFER: begin
                if (sel_val) begin
                    val_nx  = 1'b1;
                    data_nx = sel_data;
                    if (cnt == last) begin
                        eop_nx   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 7'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            last       <= '0;
            cnt        <= '0;
            wcnt       <= '0;
            ack        <= '0;
            arb_val_o  <= 1'b0;
            arb_data_o <= '0;
            arb_id_o   <= '0;
            arb_sop_o  <= 1'b0;
            arb_eop_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            ptr        <= ptr_nx;
            last       <= last_nx;
            cnt        <= cnt_nx;
            wcnt       <= wcnt_nx;
            ack        <= ack_nx;
            arb_val_o  <= val_nx;
            arb_data_o <= data_nx;
            arb_id_o   <= id_nx;
            arb_sop_o  <= sop_nx;
            arb_eop_o  <= eop_nx;
            err_o      <= err_nx;
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: grant order, beat forwarding, sop/eop,
// busy gating, timeout abort and asynchronous reset.
module tb_mcdf_arbiter;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        req = '0, val = '0;
    logic [2:0][31:0]  data = '0;
    logic [2:0][2:0]   len = '0;
    logic              fmt_busy = 1'b0;

    logic [2:0]  ack;
    logic        arb_val_o, arb_sop_o, arb_eop_o, err_o;
    logic [31:0] arb_data_o;
    logic [1:0]  arb_id_o;
    logic [40:0] outs;

    int total = 0;
    int bad = 0;

    mcdf_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .slv0_req_i(req[0]), .slv0_val_i(val[0]), .slv0_data_i(data[0]), .slv0_pkglen_i(len[0]),
        .slv1_req_i(req[1]), .slv1_val_i(val[1]), .slv1_data_i(data[1]), .slv1_pkglen_i(len[1]),
        .slv2_req_i(req[2]), .slv2_val_i(val[2]), .slv2_data_i(data[2]), .slv2_pkglen_i(len[2]),
        .fmt_busy_i(fmt_busy),
        .a2s0_ack_o(ack[0]), .a2s1_ack_o(ack[1]), .a2s2_ack_o(ack[2]),
        .arb_val_o(arb_val_o), .arb_data_o(arb_data_o), .arb_id_o(arb_id_o),
        .arb_sop_o(arb_sop_o), .arb_eop_o(arb_eop_o), .err_o(err_o)
    );

    assign outs = {ack, arb_val_o, arb_data_o, arb_id_o, arb_sop_o, arb_eop_o, err_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; val = '0; data = '0; len = '0; fmt_busy = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Selected channel gets (v,d); the others stream junk that must be ignored.
    task automatic set_beat(input int ch, input logic v, input logic [31:0] d);
        for (int j = 0; j < 3; j++) begin
            val[j]  = (j == ch) ? v : 1'b1;
            data[j] = (j == ch) ? d : (32'hDEAD_0000 | 32'(j));
        end
    endtask

    task automatic wait_ack(output logic [2:0] got);
        got = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack != '0) begin
                got = ack;
                break;
            end
        end
    endtask

    // Called in the cycle after the ack cycle.
    task automatic xfer(input int ch, input int nb, input logic [31:0] base,
                        input int gap_at, input bit extra);
        for (int i = 0; i < nb; i++) begin
            if (i == gap_at) begin
                set_beat(ch, 1'b0, 32'hFFFF_FFFF);
                step();
                chk("gap", {arb_val_o, arb_data_o}, {1'b0, 32'(base + 32'(i - 1))});
            end
            set_beat(ch, 1'b1, 32'(base + 32'(i)));
            step();
            chk("beat", {arb_val_o, arb_id_o, arb_sop_o, arb_eop_o, arb_data_o},
                {1'b1, 2'(ch), 1'(i == 0), 1'(i == nb - 1), 32'(base + 32'(i))});
        end
        if (extra) begin
            set_beat(ch, 1'b1, 32'h0000_0BAD);
            step();
            chk("extra_beat", {arb_val_o, arb_eop_o}, 2'b00);
        end
        val = '0;
    endtask

    logic [2:0] g;

    initial begin
        // Idle after reset: everything stays 0.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            chk("idle_zero", outs, '0);
            step();
        end

        // Single 4-beat packet on ch1.
        req[1] = 1'b1; len[1] = 3'd0;
        wait_ack(g);
        chk("ack_ch1", g, 3'b010);
        req[1] = 1'b0;
        step();
        chk("ack_pulse", ack, 3'b000);
        xfer(1, 4, 32'hA0, -1, 1'b0);
        step();
        chk("hold_data", {arb_val_o, arb_data_o}, {1'b0, 32'hA3});

        // Round-robin with all three requesting, 8-beat packets.
        do_reset();
        req = 3'b111; len = {3'd1, 3'd1, 3'd1};
        for (int k = 0; k < 4; k++) begin
            wait_ack(g);
            chk("rr_grant", g, 3'b001 << (k % 3));
            step();
            xfer(k % 3, 8, 32'h100 * 32'(k + 1), -1, 1'b0);
        end
        req = '0;

        // Busy formatter blocks the grant; busy mid-packet has no effect.
        do_reset();
        req[2] = 1'b1; len[2] = 3'd0; fmt_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("busy_noack", ack, 3'b000);
        end
        fmt_busy = 1'b0;
        step();
        chk("ack_after_busy", ack, 3'b100);
        req[2] = 1'b0; fmt_busy = 1'b1;
        step();
        xfer(2, 4, 32'hB0, -1, 1'b0);
        fmt_busy = 1'b0;

        // Timeout: ch0 never sends; err exactly TIMEOUT cycles after ack, then ch1.
        do_reset();
        req = 3'b011; len = '0;
        wait_ack(g);
        chk("ack_ch0_to", g, 3'b001);
        req[0] = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            chk("pre_err", {err_o, ack}, 4'b0000);
        end
        step();
        chk("err_pulse", {err_o, arb_val_o, arb_eop_o}, 3'b100);
        step();
        chk("after_err_ack_ch1", {err_o, ack}, {1'b0, 3'b010});
        req[1] = 1'b0;
        step();
        xfer(1, 4, 32'hC0, -1, 1'b0);

        // Reset mid-packet on ch2; afterwards ch0 wins.
        do_reset();
        req[2] = 1'b1; len[2] = 3'd2; len[0] = 3'd0;
        wait_ack(g);
        chk("ack_ch2", g, 3'b100);
        req[2] = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            set_beat(2, 1'b1, 32'hD0 + 32'(i));
            step();
        end
        chk("beat2_seen", {arb_val_o, arb_data_o}, {1'b1, 32'hD2});
        rst_n = 1'b0;
        #1;
        chk("rst_async", outs, '0);
        val = '0;
        step();
        chk("rst_hold", outs, '0);
        req = 3'b101;
        rst_n = 1'b1;
        step();
        chk("post_rst_ack", {ack, err_o, arb_eop_o}, {3'b001, 2'b00});
        req = '0;
        step();
        xfer(0, 4, 32'hE0, -1, 1'b0);

        // Code 7 means 64 beats; gap holds the count; surplus beat ignored.
        do_reset();
        req[0] = 1'b1; len[0] = 3'd7;
        wait_ack(g);
        chk("ack_long", g, 3'b001);
        req[0] = 1'b0;
        step();
        xfer(0, 64, 32'h1000, 5, 1'b1);
        step();
        chk("long_idle", {ack, err_o}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
